// File: rtl/cameralink_tx_pkg.sv
// Shared types and constants for the Camera Link Medium transmit framer.
// Port packing is expressed as bit offsets into the 48-bit {px3,px2,px1,px0} beat.
package cameralink_tx_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    localparam logic MODE_BASE   = 1'b0;
    localparam logic MODE_MEDIUM = 1'b1;

    localparam int unsigned PORT_A_LSB    = 0;
    localparam int unsigned PORT_B_HI_LSB = 20;
    localparam int unsigned PORT_B_LO_LSB = 8;
    localparam int unsigned PORT_C_LSB    = 12;
    localparam int unsigned PORT_D_LSB    = 24;
    localparam int unsigned PORT_E_HI_LSB = 44;
    localparam int unsigned PORT_E_LO_LSB = 32;
    localparam int unsigned PORT_F_LSB    = 36;

    typedef enum logic [2:0] {
        StIdle,
        StFvSetup,
        StLine,
        StHblank,
        StFvHold,
        StVblank
    } tx_state_e;

endpackage

// File: rtl/cameralink_px_pack.sv
// Registered pixel-to-port packing stage. Ports hold their value when no beat is
// accepted; channel-2 ports and DVAL are forced low in Base mode.
module cameralink_px_pack
    import cameralink_tx_pkg::*;
#(
    parameter int unsigned PIX_W = 12
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [4*PIX_W-1:0] beat_i,
    input  logic               valid_i,
    input  logic               mode_i,
    output logic [7:0]         port_a_o,
    output logic [7:0]         port_b_o,
    output logic [7:0]         port_c_o,
    output logic [7:0]         port_d_o,
    output logic [7:0]         port_e_o,
    output logic [7:0]         port_f_o,
    output logic               dval1_o,
    output logic               dval2_o
);

    logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d, f_q, f_d;
    logic       dval1_q, dval1_d, dval2_q, dval2_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        e_d = e_q;
        f_d = f_q;
        if (valid_i) begin
            a_d = beat_i[PORT_A_LSB +: 8];
            b_d = {beat_i[PORT_B_HI_LSB +: 4], beat_i[PORT_B_LO_LSB +: 4]};
            c_d = beat_i[PORT_C_LSB +: 8];
        end
        if (mode_i == MODE_MEDIUM) begin
            if (valid_i) begin
                d_d = beat_i[PORT_D_LSB +: 8];
                e_d = {beat_i[PORT_E_HI_LSB +: 4], beat_i[PORT_E_LO_LSB +: 4]};
                f_d = beat_i[PORT_F_LSB +: 8];
            end
        end else begin
            d_d = '0;
            e_d = '0;
            f_d = '0;
        end
        dval1_d = valid_i;
        dval2_d = valid_i && (mode_i == MODE_MEDIUM);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            dval1_q <= 1'b0;
            dval2_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            f_q     <= f_d;
            dval1_q <= dval1_d;
            dval2_q <= dval2_d;
        end
    end

    assign port_a_o = a_q;
    assign port_b_o = b_q;
    assign port_c_o = c_q;
    assign port_d_o = d_q;
    assign port_e_o = e_q;
    assign port_f_o = f_q;
    assign dval1_o  = dval1_q;
    assign dval2_o  = dval2_q;

endmodule

// File: rtl/cameralink_medium_tx_framer.sv
// Camera Link Base/Medium transmit framer: frame/line timing FSM with shadowed
// configuration, feeding a registered packing stage that produces ports A-F.
module cameralink_medium_tx_framer
    import cameralink_tx_pkg::*;
#(
    parameter int unsigned PIX_W = 12,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               enable,
    input  logic               cameraSel,
    input  logic [CNT_W-1:0]   lineWidth,
    input  logic [CNT_W-1:0]   frameLines,
    input  logic [CNT_W-1:0]   hBlank,
    input  logic [CNT_W-1:0]   vBlank,
    input  logic [4*PIX_W-1:0] pixel_data_i,
    input  logic               pixel_vld_i,
    output logic               pixel_rdy_o,
    output logic [7:0]         portA,
    output logic [7:0]         portB,
    output logic [7:0]         portC,
    output logic [7:0]         portD,
    output logic [7:0]         portE,
    output logic [7:0]         portF,
    output logic               FVAL1,
    output logic               LVAL1,
    output logic               DVAL1,
    output logic               FVAL2,
    output logic               LVAL2,
    output logic               DVAL2,
    output logic               frame_done,
    output logic [15:0]        frame_cnt,
    output logic               underrun,
    output logic               cfg_err
);

    localparam int unsigned BEAT_W = CNT_W - 1;

    function automatic logic [BEAT_W-1:0] beats_of(input logic [CNT_W-1:0] w, input logic mode);
        return (mode == MODE_MEDIUM) ? {1'b0, w[CNT_W-1:2]} : w[CNT_W-1:1];
    endfunction

    tx_state_e         state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d, beats_s_q, beats_s_d;
    logic [CNT_W-1:0]  line_cnt_q, line_cnt_d, blank_cnt_q, blank_cnt_d;
    logic [CNT_W-1:0]  lines_s_q, lines_s_d, hblank_s_q, hblank_s_d, vblank_s_q, vblank_s_d;
    logic              mode_s_q, mode_s_d;
    logic              fval_q, fval_d, lval_q, lval_d, fval2_q, fval2_d, lval2_q, lval2_d;
    logic              frame_done_q, frame_done_d, underrun_q, underrun_d;
    logic              cfg_err_q, cfg_err_d, enable_q;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              accept, cfg_ok, start_ok, load_cfg, blank_last;

    assign pixel_rdy_o = (state_q == StLine);
    assign accept      = pixel_rdy_o && pixel_vld_i;
    assign cfg_ok      = (lineWidth != '0) && (frameLines != '0) &&
                         (beats_of(lineWidth, cameraSel) != '0);
    assign start_ok    = enable && cfg_ok;
    assign blank_last  = (blank_cnt_q <= CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_cnt_d  = line_cnt_q;
        blank_cnt_d = blank_cnt_q;
        load_cfg    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    load_cfg    = 1'b1;
                    blank_cnt_d = hBlank;
                    state_d     = StFvSetup;
                end
            end
            StFvSetup, StHblank: begin
                if (blank_last) state_d = StLine;
                else            blank_cnt_d = blank_cnt_q - CNT_W'(1);
            end
            StLine: begin
                if (accept) begin
                    if (beat_cnt_q == beats_s_q - BEAT_W'(1)) begin
                        beat_cnt_d  = '0;
                        blank_cnt_d = hblank_s_q;
                        if (line_cnt_q == lines_s_q - CNT_W'(1)) begin
                            line_cnt_d = '0;
                            state_d    = StFvHold;
                        end else begin
                            line_cnt_d = line_cnt_q + CNT_W'(1);
                            state_d    = StHblank;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            StFvHold: begin
                if (blank_last) begin
                    blank_cnt_d = vblank_s_q;
                    state_d     = StVblank;
                end else begin
                    blank_cnt_d = blank_cnt_q - CNT_W'(1);
                end
            end
            StVblank: begin
                if (blank_last) begin
                    if (start_ok) begin
                        load_cfg    = 1'b1;
                        blank_cnt_d = hBlank;
                        state_d     = StFvSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    blank_cnt_d = blank_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        beats_s_d  = load_cfg ? beats_of(lineWidth, cameraSel) : beats_s_q;
        lines_s_d  = load_cfg ? frameLines : lines_s_q;
        hblank_s_d = load_cfg ? hBlank : hblank_s_q;
        vblank_s_d = load_cfg ? vBlank : vblank_s_q;
        mode_s_d   = load_cfg ? cameraSel : mode_s_q;
        // Control bits are registered once so they line up with the packed data.
        fval_d       = state_q inside {StFvSetup, StLine, StHblank, StFvHold};
        lval_d       = (state_q == StLine);
        fval2_d      = fval_d && (mode_s_q == MODE_MEDIUM);
        lval2_d      = lval_d && (mode_s_q == MODE_MEDIUM);
        frame_done_d = fval_q && !fval_d;
        frame_cnt_d  = frame_cnt_q + 16'(frame_done_d);
        underrun_d   = (enable && !enable_q) ? 1'b0
                                             : (underrun_q || (pixel_rdy_o && !pixel_vld_i));
        cfg_err_d    = (state_q == StIdle) && enable && !cfg_ok;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            beat_cnt_q   <= '0;
            line_cnt_q   <= '0;
            blank_cnt_q  <= '0;
            beats_s_q    <= '0;
            lines_s_q    <= '0;
            hblank_s_q   <= '0;
            vblank_s_q   <= '0;
            mode_s_q     <= MODE_BASE;
            fval_q       <= 1'b0;
            lval_q       <= 1'b0;
            fval2_q      <= 1'b0;
            lval2_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            underrun_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            line_cnt_q   <= line_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
            beats_s_q    <= beats_s_d;
            lines_s_q    <= lines_s_d;
            hblank_s_q   <= hblank_s_d;
            vblank_s_q   <= vblank_s_d;
            mode_s_q     <= mode_s_d;
            fval_q       <= fval_d;
            lval_q       <= lval_d;
            fval2_q      <= fval2_d;
            lval2_q      <= lval2_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            underrun_q   <= underrun_d;
            cfg_err_q    <= cfg_err_d;
            enable_q     <= enable;
        end
    end

    cameralink_px_pack #(
        .PIX_W(PIX_W)
    ) u_pack (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .beat_i  (pixel_data_i),
        .valid_i (accept),
        .mode_i  (mode_s_q),
        .port_a_o(portA),
        .port_b_o(portB),
        .port_c_o(portC),
        .port_d_o(portD),
        .port_e_o(portE),
        .port_f_o(portF),
        .dval1_o (DVAL1),
        .dval2_o (DVAL2)
    );

    assign FVAL1      = fval_q;
    assign LVAL1      = lval_q;
    assign FVAL2      = fval2_q;
    assign LVAL2      = lval2_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign underrun   = underrun_q;
    assign cfg_err    = cfg_err_q;

endmodule
